// File: rtl/reg2_bank_pkg.sv
// Shared types and the round-robin pick function for the 2-bit register bank
// write scheduler.
package reg2_bank_pkg;

  localparam int REG_W   = 2;
  localparam int MAX_REQ = 16;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } state_t;

  typedef struct packed {
    logic       found;
    logic [3:0] idx;
  } pick_t;

  // First set bit of valid, searching upward from ptr and wrapping at n.
  function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] valid,
                                    input logic [3:0]         ptr,
                                    input int unsigned        n);
    pick_t       res;
    int unsigned cand;
    res = '0;
    for (int unsigned k = 0; k < MAX_REQ; k++) begin
      cand = 32'(ptr) + k;
      if (cand >= n) cand = cand - n;
      if (k < n && !res.found && valid[cand[3:0]]) begin
        res.found = 1'b1;
        res.idx   = cand[3:0];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/reg2_bank_write_sched_rr_arbiter.sv
// Combinational round-robin arbiter: returns the first valid requester at or
// after the pointer, with wrap-around.
module rr_arbiter
  import reg2_bank_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid_i,
  input  logic [ID_W-1:0]    ptr_i,
  output logic [ID_W-1:0]    idx_o,
  output logic               found_o
);

  pick_t pick;

  always_comb begin
    pick    = rr_pick(MAX_REQ'(valid_i), 4'(ptr_i), NUM_REQ);
    found_o = pick.found;
    idx_o   = ID_W'(pick.idx);
  end

endmodule

// File: rtl/reg2_bank_write_sched.sv
// Round-robin write scheduler holding a shadow copy of a bank of 2-bit
// load-every-cycle registers. Optional write counter: WRITE_COUNT_EN.
module reg2_bank_write_sched
  import reg2_bank_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int GROUPSIZE = 8,
  parameter int ADDR_W    = $clog2(GROUPSIZE)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0]    req_addr,
  input  logic [NUM_REQ*REG_W-1:0]     req_data,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic [GROUPSIZE*REG_W-1:0]   bank_data_in,
  output logic [$clog2(NUM_REQ)-1:0]   grant_id,
  output logic                         busy,
  output logic                         addr_err
`ifdef WRITE_COUNT_EN
  ,
  output logic [15:0]                  wr_count
`endif
);

  localparam int          ID_W = $clog2(NUM_REQ);
  localparam logic [31:0] GS_U = GROUPSIZE;

  state_t                 state_q, state_d;
  logic [ID_W-1:0]        grant_q, grant_d;
  logic [ID_W-1:0]        rr_ptr_q;
  logic [REG_W-1:0]       shadow_q [GROUPSIZE];
  logic                   addr_err_q;

  logic [ID_W-1:0]        win_idx;
  logic                   win_found;
  logic [ADDR_W-1:0]      wr_addr;
  logic [REG_W-1:0]       wr_data;
  logic                   in_range;
  logic                   wr_fire;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .valid_i (req_valid),
    .ptr_i   (rr_ptr_q),
    .idx_o   (win_idx),
    .found_o (win_found)
  );

  assign wr_addr  = req_addr[grant_q*ADDR_W +: ADDR_W];
  assign wr_data  = req_data[grant_q*REG_W +: REG_W];
  assign in_range = 32'(wr_addr) < GS_U;
  assign wr_fire  = (state_q == WRITE);

  // NOTE: every combinational output gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    unique case (state_q)
      IDLE: begin
        if (win_found) begin
          grant_d = win_idx;
          state_d = WRITE;
        end
      end
      WRITE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      rr_ptr_q   <= '0;
      addr_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      addr_err_q <= wr_fire && !in_range;
      if (wr_fire) begin
        rr_ptr_q <= (grant_q == ID_W'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
      end
    end
  end

  // NOTE: the shadow is reset because it drives the register bank directly;
  // the bank must see known zeros out of reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < GROUPSIZE; k++) shadow_q[k] <= '0;
    end else if (wr_fire && in_range) begin
      for (int k = 0; k < GROUPSIZE; k++) begin
        if (wr_addr == ADDR_W'(k)) shadow_q[k] <= wr_data;
      end
    end
  end

`ifdef WRITE_COUNT_EN
  logic [15:0] wr_count_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_count_q <= '0;
    end else if (wr_fire && in_range && wr_count_q != 16'hFFFF) begin
      wr_count_q <= wr_count_q + 16'd1;
    end
  end

  assign wr_count = wr_count_q;
`endif

  always_comb begin
    bank_data_in = '0;
    for (int k = 0; k < GROUPSIZE; k++) begin
      bank_data_in[k*REG_W +: REG_W] = shadow_q[k];
    end
  end

  // Ready is decoded straight from state so it is a clean one-cycle pulse.
  assign req_ready = wr_fire ? (NUM_REQ'(1) << grant_q) : '0;
  assign grant_id  = grant_q;
  assign busy      = wr_fire;
  assign addr_err  = addr_err_q;

endmodule

// File: tb/tb_reg2_bank_write_sched.sv
// Directed self-checking bench for reg2_bank_write_sched (NUM_REQ=4,
// GROUPSIZE=6 so out-of-range addresses are reachable).
module tb_reg2_bank_write_sched;

  localparam int NUM_REQ   = 4;
  localparam int GROUPSIZE = 6;
  localparam int ADDR_W    = 3;
  localparam int ID_W      = 2;

  logic                        clk;
  logic                        reset_n;
  logic [NUM_REQ-1:0]          req_valid;
  logic [NUM_REQ*ADDR_W-1:0]   req_addr;
  logic [NUM_REQ*2-1:0]        req_data;
  logic [NUM_REQ-1:0]          req_ready;
  logic [GROUPSIZE*2-1:0]      bank_data_in;
  logic [ID_W-1:0]             grant_id;
  logic                        busy;
  logic                        addr_err;
`ifdef WRITE_COUNT_EN
  logic [15:0]                 wr_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  reg2_bank_write_sched #(
    .NUM_REQ   (NUM_REQ),
    .GROUPSIZE (GROUPSIZE),
    .ADDR_W    (ADDR_W)
  ) u_dut (
    .clk          (clk),
    .reset        (reset_n),
    .req_valid    (req_valid),
    .req_addr     (req_addr),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .bank_data_in (bank_data_in),
    .grant_id     (grant_id),
    .busy         (busy),
    .addr_err     (addr_err)
`ifdef WRITE_COUNT_EN
    ,
    .wr_count     (wr_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [ADDR_W-1:0] a, input logic [1:0] d);
    req_addr[i*ADDR_W +: ADDR_W] = a;
    req_data[i*2 +: 2]           = d;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    tick();
    reset_n = 1'b1;
  endtask

  initial begin
    int exp_order [5] = '{0, 1, 2, 3, 0};

    reset_n   = 1'b1;
    req_valid = '0;
    req_addr  = '0;
    req_data  = '0;
    #2;

    // Reset state
    do_reset();
    check("rst_bank",  bank_data_in, 0);
    check("rst_ready", req_ready, 0);
    check("rst_busy",  busy, 0);
    check("rst_grant", grant_id, 0);
    check("rst_aerr",  addr_err, 0);
    repeat (5) tick();
    check("idle_bank",  bank_data_in, 0);
    check("idle_ready", req_ready, 0);
    check("idle_busy",  busy, 0);

    // Single write: requester 2, addr 5, data 11
    set_req(2, 3'd5, 2'b11);
    req_valid = 4'b0100;
    tick();
    check("w1_ready", req_ready, 4'b0100);
    check("w1_busy",  busy, 1);
    check("w1_grant", grant_id, 2);
    tick();
    req_valid = '0;
    check("w1_bank",      bank_data_in, 12'hC00);
    check("w1_ready_off", req_ready, 0);

    // All requesters valid continuously, rr_ptr = 0 after reset
    do_reset();
    set_req(0, 3'd0, 2'b01);
    set_req(1, 3'd1, 2'b10);
    set_req(2, 3'd2, 2'b11);
    set_req(3, 3'd3, 2'b01);
    req_valid = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      tick();
      check($sformatf("rr_ready_%0d", g), req_ready, 4'b0001 << exp_order[g]);
      check($sformatf("rr_grant_%0d", g), grant_id, exp_order[g]);
      tick();
      check($sformatf("rr_gap_%0d", g), req_ready, 0);
    end
    req_valid = '0;
    check("rr_bank", bank_data_in, 12'h079);

    // Same address from requesters 1 and 3, rr_ptr = 1
    set_req(1, 3'd0, 2'b01);
    set_req(3, 3'd0, 2'b10);
    req_valid = 4'b1010;
    tick();
    check("same_ready1", req_ready, 4'b0010);
    tick();
    req_valid = 4'b1000;
    check("same_slice0_a", bank_data_in[1:0], 2'b01);
    tick();
    check("same_ready3", req_ready, 4'b1000);
    check("same_grant3", grant_id, 3);
    tick();
    req_valid = '0;
    check("same_bank", bank_data_in, 12'h07A);

    // Out-of-range address 7 with GROUPSIZE = 6
    set_req(0, 3'd7, 2'b11);
    req_valid = 4'b0001;
    tick();
    check("oor_ready",     req_ready, 4'b0001);
    check("oor_aerr_pre",  addr_err, 0);
    tick();
    req_valid = '0;
    check("oor_aerr",      addr_err, 1);
    check("oor_bank",      bank_data_in, 12'h07A);
    tick();
    check("oor_aerr_post", addr_err, 0);
`ifdef WRITE_COUNT_EN
    check("oor_count", wr_count, 7);
`endif

    // Reset during WRITE: write discarded, request re-arbitrated from 0
    set_req(0, 3'd3, 2'b01);
    req_valid = 4'b0001;
    tick();
    reset_n = 1'b0;
    #1;
    check("rw_ready", req_ready, 0);
    check("rw_busy",  busy, 0);
    check("rw_bank",  bank_data_in, 0);
    tick();
    reset_n = 1'b1;
    tick();
    check("rw_regrant_ready", req_ready, 4'b0001);
    check("rw_regrant_id",    grant_id, 0);
    tick();
    req_valid = '0;
    check("rw_bank_after", bank_data_in, 12'h040);
`ifdef WRITE_COUNT_EN
    check("rw_count", wr_count, 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
